// File: rtl/coin_collector.sv
// coin_collector
//   Front end of the customer purchase path. It accepts coins in customer mode
//   and accumulates a 7-bit credit. On a purchase request it hands money/amount
//   to the purchase stage for a single cycle. It then captures the stage's
//   result and pays it out as change. Cancel, inactivity timeout and leaving
//   customer mode all refund the current credit.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   mode[1:0]           2'b01 = customer mode; any other value blocks coins
//   coin_valid          one-cycle coin strobe, value given by coin_type
//   coin_type[1:0]      00=1, 01=2, 10=5, 11=10 credit units
//   buy_req             one-cycle purchase request for amount_in items
//   amount_in[3:0]      requested item count, sampled with buy_req
//   cancel              one-cycle abort-and-refund strobe
//   remaining_money[6:0] purchase stage result, sampled in RESULT
//   red_light           purchase stage failure flag, sampled in RESULT
//   money[6:0]          current credit presented to the purchase stage
//   amount[3:0]         latched item count presented to the purchase stage
//   purchase_strobe     high for the single PURCHASE cycle
//   coin_reject         one-cycle pulse: a coin was returned
//   change_valid        one-cycle pulse: change holds the payout
//   change[6:0]         payout value
//   purchase_fail       pulses with change_valid when the purchase failed
module coin_collector #(
  parameter int MAX_CREDIT     = 127,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       buy_req,
  input  logic [3:0] amount_in,
  input  logic       cancel,
  input  logic [6:0] remaining_money,
  input  logic       red_light,
  output logic [6:0] money,
  output logic [3:0] amount,
  output logic       purchase_strobe,
  output logic       coin_reject,
  output logic       change_valid,
  output logic [6:0] change,
  output logic       purchase_fail
);

  // The timer only has to count up to TIMEOUT_CYCLES-1.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    PURCHASE = 3'd2,
    RESULT   = 3'd3,
    PAYOUT   = 3'd4
  } state_t;

  function automatic logic [6:0] coin_value(input logic [1:0] kind);
    case (kind)
      2'b00:   return 7'd1;
      2'b01:   return 7'd2;
      2'b10:   return 7'd5;
      default: return 7'd10;
    endcase
  endfunction

  // Sum is formed one bit wider so a coin pushing past 127 cannot wrap.
  function automatic logic [7:0] credit_sum(input logic [6:0] credit,
                                            input logic [6:0] value);
    return {1'b0, credit} + {1'b0, value};
  endfunction

  function automatic logic credit_fits(input logic [7:0] sum);
    return sum <= 8'(MAX_CREDIT);
  endfunction

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [6:0]         money_nxt, change_nxt;
  logic [3:0]         amount_nxt;
  logic               strobe_nxt, reject_nxt, change_valid_nxt, fail_nxt;
  logic               customer;
  logic [7:0]         sum;

  assign customer = (mode == 2'b01);
  assign sum      = credit_sum(money, coin_value(coin_type));

  always_comb begin
    state_nxt        = state;
    timer_nxt        = timer;
    money_nxt        = money;
    amount_nxt       = amount;
    change_nxt       = change;
    strobe_nxt       = 1'b0;
    reject_nxt       = 1'b0;
    change_valid_nxt = 1'b0;
    fail_nxt         = 1'b0;

    case (state)
      IDLE: begin
        if (coin_valid) begin
          if (customer) begin
            money_nxt = coin_value(coin_type);
            timer_nxt = '0;
            state_nxt = COLLECT;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end

      COLLECT: begin
        // Mode exit beats cancel, which beats buy, which beats a coin.
        if (!customer || cancel) begin
          reject_nxt       = coin_valid;
          change_nxt       = money;
          change_valid_nxt = 1'b1;
          state_nxt        = PAYOUT;
        end else if (buy_req && (amount_in != 4'd0)) begin
          reject_nxt = coin_valid;
          amount_nxt = amount_in;
          strobe_nxt = 1'b1;
          timer_nxt  = '0;
          state_nxt  = PURCHASE;
        end else if (coin_valid) begin
          timer_nxt = '0;
          if (credit_fits(sum)) money_nxt  = sum[6:0];
          else                  reject_nxt = 1'b1;
        end else if (buy_req) begin
          // A zero-item request is ignored but still counts as activity.
          timer_nxt = '0;
        end else if (timer == TIMER_LAST) begin
          change_nxt       = money;
          change_valid_nxt = 1'b1;
          state_nxt        = PAYOUT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      PURCHASE: begin
        reject_nxt = coin_valid;
        state_nxt  = RESULT;
      end

      RESULT: begin
        reject_nxt       = coin_valid;
        change_nxt       = remaining_money;
        change_valid_nxt = 1'b1;
        fail_nxt         = red_light;
        state_nxt        = PAYOUT;
      end

      PAYOUT: begin
        reject_nxt = coin_valid;
        money_nxt  = '0;
        amount_nxt = '0;
        state_nxt  = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: every output is driven straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      timer           <= '0;
      money           <= '0;
      amount          <= '0;
      change          <= '0;
      purchase_strobe <= 1'b0;
      coin_reject     <= 1'b0;
      change_valid    <= 1'b0;
      purchase_fail   <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      money           <= money_nxt;
      amount          <= amount_nxt;
      change          <= change_nxt;
      purchase_strobe <= strobe_nxt;
      coin_reject     <= reject_nxt;
      change_valid    <= change_valid_nxt;
      purchase_fail   <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_coin_collector.sv
module tb_coin_collector;

  localparam int MAXC = 127;
  localparam int TMO  = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       buy_req;
  logic [3:0] amount_in;
  logic       cancel;
  logic [6:0] remaining_money;
  logic       red_light;
  logic [6:0] money;
  logic [3:0] amount;
  logic       purchase_strobe;
  logic       coin_reject;
  logic       change_valid;
  logic [6:0] change;
  logic       purchase_fail;

  coin_collector #(.MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode            (mode),
    .coin_valid      (coin_valid),
    .coin_type       (coin_type),
    .buy_req         (buy_req),
    .amount_in       (amount_in),
    .cancel          (cancel),
    .remaining_money (remaining_money),
    .red_light       (red_light),
    .money           (money),
    .amount          (amount),
    .purchase_strobe (purchase_strobe),
    .coin_reject     (coin_reject),
    .change_valid    (change_valid),
    .change          (change),
    .purchase_fail   (purchase_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Expected output events, stamped with the clock edge after which they show.
  typedef struct { int stamp; int a; int b; } ev_t;
  int  rej_q[$];
  ev_t pur_q[$];
  ev_t chg_q[$];
  ev_t mon_q[$];

  function automatic ev_t mk(input int s, input int a, input int b);
    ev_t e;
    e.stamp = s; e.a = a; e.b = b;
    return e;
  endfunction

  // Mock purchase stage: items cost price each; fails when credit is short.
  int price = 0;
  always @(posedge clk) begin
    if (purchase_strobe) begin
      if (int'(amount) * price > int'(money)) begin
        red_light       <= 1'b1;
        remaining_money <= money;
      end else begin
        red_light       <= 1'b0;
        remaining_money <= 7'(int'(money) - int'(amount) * price);
      end
    end else begin
      red_light       <= 1'($urandom);
      remaining_money <= 7'($urandom);
    end
  end

  // Reference model: credit, a "collecting" flag, a count of idle edges and
  // a count of edges during which the machine is busy paying out.
  int coin_vals[4] = '{1, 2, 5, 10};
  int m_credit = 0;
  bit m_collecting = 0;
  int m_idle = 0;
  int m_busy = 0;

  task automatic model_step(input int e, input bit cv, input bit [1:0] ct,
                            input bit b, input bit [3:0] amt, input bit cn,
                            input bit [1:0] md);
    int v;
    int cost;
    bit rej;
    v   = coin_vals[ct];
    rej = 1'b0;
    if (m_busy > 0) begin
      rej = cv;
      m_busy--;
      if (m_busy == 0) begin
        m_credit     = 0;
        m_collecting = 1'b0;
      end
    end else if (!m_collecting) begin
      if (cv) begin
        if (md == 2'b01) begin
          m_credit     = v;
          m_collecting = 1'b1;
          m_idle       = 0;
        end else rej = 1'b1;
      end
    end else if (md != 2'b01 || cn) begin
      rej = cv;
      chg_q.push_back(mk(e, m_credit, 0));
      m_busy = 1;
    end else if (b && amt != 0) begin
      rej  = cv;
      cost = int'(amt) * price;
      pur_q.push_back(mk(e, m_credit, int'(amt)));
      if (cost > m_credit) chg_q.push_back(mk(e + 2, m_credit, 1));
      else                 chg_q.push_back(mk(e + 2, m_credit - cost, 0));
      m_busy = 3;
    end else if (cv) begin
      m_idle = 0;
      if (m_credit + v > MAXC) rej = 1'b1;
      else m_credit += v;
    end else if (b) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        chg_q.push_back(mk(e, m_credit, 0));
        m_busy = 1;
      end
    end
    if (rej) rej_q.push_back(e);
    mon_q.push_back(mk(e, m_credit, 0));
  endtask

  task automatic drive(input bit cv, input bit [1:0] ct, input bit b,
                       input bit [3:0] amt, input bit cn, input bit [1:0] md);
    @(negedge clk);
    coin_valid = cv;
    coin_type  = ct;
    buy_req    = b;
    amount_in  = amt;
    cancel     = cn;
    mode       = md;
    model_step(cyc + 1, cv, ct, b, amt, cn, md);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 2'b01);
  endtask

  task automatic coin(input bit [1:0] ct);
    drive(1'b1, ct, 1'b0, 4'd0, 1'b0, 2'b01);
  endtask

  task automatic flush_model();
    rej_q.delete(); pur_q.delete(); chg_q.delete(); mon_q.delete();
    m_credit = 0; m_collecting = 1'b0; m_idle = 0; m_busy = 0;
  endtask

  // Monitor: compares whatever the DUT presents against the queue heads.
  bit mon_en = 1'b0;
  bit ep;
  always @(negedge clk) begin
    if (mon_en) begin
      ep = 1'b0;
      if (rej_q.size() > 0) ep = (rej_q[0] == cyc);
      if (ep || coin_reject) check("coin_reject", int'(coin_reject), int'(ep));
      if (ep) void'(rej_q.pop_front());

      ep = 1'b0;
      if (pur_q.size() > 0) ep = (pur_q[0].stamp == cyc);
      if (ep || purchase_strobe) check("purchase_strobe", int'(purchase_strobe), int'(ep));
      if (ep && purchase_strobe) begin
        check("purchase_money", int'(money), pur_q[0].a);
        check("purchase_amount", int'(amount), pur_q[0].b);
      end
      if (ep) void'(pur_q.pop_front());

      ep = 1'b0;
      if (chg_q.size() > 0) ep = (chg_q[0].stamp == cyc);
      if (ep || change_valid) check("change_valid", int'(change_valid), int'(ep));
      if (ep && change_valid) begin
        check("change", int'(change), chg_q[0].a);
        check("purchase_fail", int'(purchase_fail), chg_q[0].b);
      end
      if (ep) void'(chg_q.pop_front());
      if (purchase_fail && !change_valid) check("purchase_fail_alone", int'(purchase_fail), 0);

      if (mon_q.size() > 0 && mon_q[0].stamp == cyc) begin
        check("money", int'(money), mon_q[0].a);
        void'(mon_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_money"}, int'(money), 0);
    check({tag, "_amount"}, int'(amount), 0);
    check({tag, "_strobe"}, int'(purchase_strobe), 0);
    check({tag, "_reject"}, int'(coin_reject), 0);
    check({tag, "_change_valid"}, int'(change_valid), 0);
    check({tag, "_change"}, int'(change), 0);
    check({tag, "_fail"}, int'(purchase_fail), 0);
  endtask

  task automatic rand_phase(input int n, input int p_coin, input int p_buy,
                            input int p_cancel, input int p_mode);
    for (int i = 0; i < n; i++) begin
      bit       cv, b, cn;
      bit [1:0] ct, md;
      bit [3:0] amt;
      if (!m_collecting && m_busy == 0 && $urandom_range(0, 3) == 0)
        price = int'($urandom_range(0, 15));
      cv  = ($urandom_range(0, 99) < p_coin);
      ct  = 2'($urandom_range(0, 3));
      b   = ($urandom_range(0, 99) < p_buy);
      amt = 4'($urandom_range(0, 15));
      cn  = ($urandom_range(0, 99) < p_cancel);
      md  = ($urandom_range(0, 99) < p_mode) ? 2'($urandom_range(0, 3)) : 2'b01;
      if (b && amt == 4'd0) cv = 1'b0;
      drive(cv, ct, b, amt, cn, md);
      if (i % 150 == 149) idle(TMO + 2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mode = 2'b01; coin_valid = 1'b0; coin_type = 2'b00;
    buy_req = 1'b0; amount_in = 4'd0; cancel = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Coins 10,5,2 then buy 3 at price 4: change 5.
    price = 4;
    coin(2'b11); coin(2'b10); coin(2'b01);
    @(posedge clk); #1 check("t1_credit", int'(money), 17);
    drive(1'b0, 2'b00, 1'b1, 4'd3, 1'b0, 2'b01);
    idle(4);
    check("t1_money_cleared", int'(money), 0);

    // Credit 10, buy 3 at price 4: fails, full refund.
    coin(2'b11);
    drive(1'b0, 2'b00, 1'b1, 4'd3, 1'b0, 2'b01);
    idle(4);

    // Fill to 120, overflow coin rejected, then a 5 fits.
    price = 1;
    repeat (12) coin(2'b11);
    coin(2'b11);
    @(posedge clk); #1;
    check("t3_overflow_reject", int'(coin_reject), 1);
    check("t3_credit_held", int'(money), 120);
    coin(2'b10);
    @(posedge clk); #1 check("t3_credit", int'(money), 125);
    drive(1'b0, 2'b00, 1'b0, 4'd0, 1'b1, 2'b01);
    idle(2);

    // Credit 7 then silence until timeout refund.
    coin(2'b10); coin(2'b01);
    idle(TMO + 3);

    // Cancel + buy + coin together at credit 6.
    coin(2'b10); coin(2'b00);
    drive(1'b1, 2'b00, 1'b1, 4'd2, 1'b1, 2'b01);
    idle(3);

    // Mode exit refunds; coin outside customer mode is rejected.
    coin(2'b01);
    drive(1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 2'b10);
    idle(1);
    drive(1'b1, 2'b11, 1'b0, 4'd0, 1'b0, 2'b00);
    idle(1);

    // Exact price: zero change still reported.
    price = 2;
    coin(2'b11);
    drive(1'b0, 2'b00, 1'b1, 4'd5, 1'b0, 2'b01);
    idle(4);

    // Reset while in RESULT: everything clears, no payout follows.
    price = 1;
    coin(2'b11);
    drive(1'b0, 2'b00, 1'b1, 4'd2, 1'b0, 2'b01);
    idle(1);
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1 check_all_zero("mid_reset");
    flush_model();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(4);
    coin(2'b10);
    idle(1);
    drive(1'b0, 2'b00, 1'b0, 4'd0, 1'b1, 2'b01);
    idle(2);

    // Randomized traffic: general mix, then long coin runs that overflow.
    rand_phase(2000, 40, 4, 2, 3);
    rand_phase(1000, 70, 1, 0, 0);

    idle(6);
    @(negedge clk);
    @(negedge clk);
    #1 check("scoreboard_drained",
             rej_q.size() + pur_q.size() + chg_q.size() + mon_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
